// File: rtl/fb_write_sched.sv
// fb_write_sched: single-port frame-buffer write scheduler.
// Pixel stream has strict priority; fill engine and host share leftover cycles round-robin.
`default_nettype none

module fb_write_sched #(
  parameter int                WIDTH      = 240,
  parameter int                HEIGHT     = 160,
  parameter int                DATA_W     = 18,
  parameter int                ADDR_W     = 16,
  parameter logic [DATA_W-1:0] INIT_COLOR = 18'b100000_100000_100000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pix_we,
  input  logic [7:0]        pix_x,
  input  logic [7:0]        pix_y,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [8:0]        W_LIM     = 9'(WIDTH);
  localparam logic [8:0]        H_LIM     = 9'(HEIGHT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_color_q, fill_color_d;
  logic              fill_done_q, fill_done_d;
  logic              rr_fill_q, rr_fill_d;
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_wdata_q;

  logic              pix_ok;
  logic [ADDR_W-1:0] pix_addr;
  logic              host_in_range;
  logic              grant_pix, grant_fill, grant_host;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign fill_busy     = (state_q == S_FILL);
  assign pix_ok        = resetn & pix_we & ({1'b0, pix_x} < W_LIM) & ({1'b0, pix_y} < H_LIM);
  assign host_in_range = (host_addr <= LAST_ADDR);

  // Constant-width multiply reduces to shift-subtract for the native GBA width.
  if (WIDTH == 240) begin : g_addr_w240
    assign pix_addr = (ADDR_W'(pix_y) << 8) - (ADDR_W'(pix_y) << 4) + ADDR_W'(pix_x);
  end else begin : g_addr_generic
    assign pix_addr = ADDR_W'(pix_y) * ADDR_W'(WIDTH) + ADDR_W'(pix_x);
  end

  always_comb begin
    grant_pix  = pix_ok;
    grant_fill = 1'b0;
    grant_host = 1'b0;
    if (resetn && !pix_ok) begin
      if (fill_busy && host_valid) begin
        grant_fill = rr_fill_q;
        grant_host = ~rr_fill_q;
      end else begin
        grant_fill = fill_busy;
        grant_host = host_valid;
      end
    end
  end

  assign host_ready = grant_host;

  always_comb begin
    rr_fill_d = rr_fill_q;
    wr_en     = 1'b0;
    wr_addr   = fill_addr_q;
    wr_data   = fill_color_q;
    if (grant_pix) begin
      wr_en   = 1'b1;
      wr_addr = pix_addr;
      wr_data = pix_data;
    end else if (grant_fill) begin
      wr_en     = 1'b1;
      rr_fill_d = 1'b0;
    end else if (grant_host) begin
      // Out-of-range host words are acknowledged but never written.
      wr_en     = host_in_range;
      wr_addr   = host_addr;
      wr_data   = host_data;
      rr_fill_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    fill_done_d  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (grant_fill) begin
          if (fill_addr_q == LAST_ADDR) begin
            state_d     = S_IDLE;
            fill_done_d = 1'b1;
          end else begin
            fill_addr_d = fill_addr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // A new start overrides completion of the pass in flight.
    if (fill_start) begin
      state_d      = S_FILL;
      fill_addr_d  = '0;
      fill_color_d = fill_color;
      fill_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_FILL;
      fill_addr_q  <= '0;
      fill_color_q <= INIT_COLOR;
      fill_done_q  <= 1'b0;
      rr_fill_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
      fill_done_q  <= fill_done_d;
      rr_fill_q    <= rr_fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      fb_we_q <= wr_en;
      if (wr_en) begin
        fb_addr_q  <= wr_addr;
        fb_wdata_q <= wr_data;
      end
    end
  end

  assign fill_done = fill_done_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_sched.sv
// tb_fb_write_sched: table vectors, hand sequences and randomized traffic against a cycle reference model.
`default_nettype none

module tb_fb_write_sched;

  localparam int NPIX = 240 * 160;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pix_we = 1'b0;
  logic [7:0]  pix_x = '0, pix_y = '0;
  logic [17:0] pix_data = '0;
  logic        fill_start = 1'b0;
  logic [17:0] fill_color = '0;
  logic        fill_busy, fill_done;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [15:0] host_addr = '0;
  logic [17:0] host_data = '0;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [17:0] fb_wdata;

  fb_write_sched dut (
    .clk(clk), .resetn(resetn),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: fill progress, whose turn it is, and the write expected next cycle.
  bit          m_known = 0;
  bit          m_act;
  int          m_ptr;
  logic [17:0] m_col;
  bit          m_turn_fill;
  bit          e_we, e_done;
  int          e_addr;
  logic [17:0] e_data;
  int          obs_we, obs_done, cyc_no, first_we_cyc, done_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout expired (t=%0t)", nm, $time);
  endtask

  task automatic idle_inputs();
    pix_we = 0; pix_x = 0; pix_y = 0; pix_data = 0;
    host_valid = 0; host_addr = 0; host_data = 0;
    fill_start = 0; fill_color = 0;
  endtask

  // One clock cycle: check current outputs against the model, then advance the model.
  task automatic cyc();
    int  g;  // 0 none, 1 pixel, 2 fill, 3 host
    bit  pok;
    #4;
    pok = pix_we && (pix_x < 240) && (pix_y < 160);
    if (!resetn)                   g = 0;
    else if (pok)                  g = 1;
    else if (m_act && host_valid)  g = m_turn_fill ? 2 : 3;
    else if (m_act)                g = 2;
    else if (host_valid)           g = 3;
    else                           g = 0;

    chk("host_ready", 32'(host_ready), 32'(g == 3));
    if (m_known) begin
      chk("fill_busy", 32'(fill_busy), 32'(m_act));
      chk("fb_we", 32'(fb_we), 32'(e_we));
      chk("fill_done", 32'(fill_done), 32'(e_done));
      if (e_we) begin
        chk("fb_addr", 32'(fb_addr), 32'(e_addr));
        chk("fb_wdata", 32'(fb_wdata), 32'(e_data));
      end
    end
    if (fb_we) begin
      if (obs_we == 0) first_we_cyc = cyc_no;
      obs_we++;
    end
    if (fill_done) begin
      obs_done++;
      done_cyc = cyc_no;
    end

    if (!resetn) begin
      m_known = 1; m_act = 1; m_ptr = 0; m_col = 18'h20820; m_turn_fill = 1;
      e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
    end else begin
      e_done = (g == 2) && (m_ptr == NPIX - 1) && !fill_start;
      e_we = 0;
      case (g)
        1: begin e_we = 1; e_addr = int'(pix_y) * 240 + int'(pix_x); e_data = pix_data; end
        2: begin e_we = 1; e_addr = m_ptr; e_data = m_col; end
        3: if (int'(host_addr) < NPIX) begin e_we = 1; e_addr = int'(host_addr); e_data = host_data; end
        default: ;
      endcase
      if (g == 2) m_turn_fill = 0;
      if (g == 3) m_turn_fill = 1;
      if (fill_start) begin
        m_act = 1; m_ptr = 0; m_col = fill_color;
      end else if (g == 2) begin
        if (m_ptr == NPIX - 1) m_act = 0;
        else m_ptr++;
      end
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_we = 0; obs_done = 0; cyc_no = 0; first_we_cyc = -1; done_cyc = -1;
  endtask

  task automatic model_reset();
    idle_inputs();
    resetn = 0;
    repeat (3) cyc();
    resetn = 1;
    clear_obs();
  endtask

  typedef struct {
    logic        pw;
    logic [7:0]  px, py;
    logic [17:0] pd;
    logic        hv;
    logic [15:0] ha;
    logic [17:0] hd;
    logic        fs;
    logic [17:0] fc;
    logic        e_rdy, e_we;
    logic [15:0] e_addr;
    logic [17:0] e_data;
  } vec_t;

  vec_t tv[16];

  initial begin
    // Rows start on the first cycle after reset release; fill at addr 0, rr on fill.
    tv[0]  = '{0,  0,  0, 18'h0,     0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd0,   18'h20820};
    tv[1]  = '{1, 10,  2, 18'h3FFFF, 0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd490, 18'h3FFFF};
    tv[2]  = '{0,  0,  0, 18'h0,     0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd1,   18'h20820};
    tv[3]  = '{1, 240, 0, 18'h11111, 0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd2,   18'h20820};
    tv[4]  = '{1,  0, 160,18'h22222, 0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd3,   18'h20820};
    tv[5]  = '{1,  1,  0, 18'h00001, 1, 16'd100,   18'h00FFF, 0, 18'h0, 0, 1, 16'd1,   18'h00001};
    tv[6]  = '{0,  0,  0, 18'h0,     1, 16'd100,   18'h00FFF, 0, 18'h0, 1, 1, 16'd100, 18'h00FFF};
    tv[7]  = '{0,  0,  0, 18'h0,     0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd4,   18'h20820};
    tv[8]  = '{0,  0,  0, 18'h0,     1, 16'd38400, 18'h00005, 0, 18'h0, 1, 0, 16'd0,   18'h0};
    tv[9]  = '{0,  0,  0, 18'h0,     0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd5,   18'h20820};
    tv[10] = '{0,  0,  0, 18'h0,     1, 16'd200,   18'h00007, 0, 18'h0, 1, 1, 16'd200, 18'h00007};
    tv[11] = '{0,  0,  0, 18'h0,     1, 16'd300,   18'h00009, 0, 18'h0, 0, 1, 16'd6,   18'h20820};
    tv[12] = '{0,  0,  0, 18'h0,     1, 16'd300,   18'h00009, 0, 18'h0, 1, 1, 16'd300, 18'h00009};
    tv[13] = '{0,  0,  0, 18'h0,     0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd7,   18'h20820};
    tv[14] = '{0,  0,  0, 18'h0,     0, 16'd0,     18'h0,     1, 18'h0, 0, 1, 16'd8,   18'h20820};
    tv[15] = '{0,  0,  0, 18'h0,     0, 16'd0,     18'h0,     0, 18'h0, 0, 1, 16'd0,   18'h0};

    // Automatic post-reset fill with no other traffic.
    model_reset();
    for (int i = 0; i < NPIX + 10 && m_act; i++) cyc();
    if (m_act) timeout("auto_fill");
    repeat (3) cyc();
    chk("auto_fill_writes", 32'(obs_we), 32'(NPIX));
    chk("auto_fill_done_count", 32'(obs_done), 32'd1);
    chk("auto_fill_done_offset", 32'(done_cyc - first_we_cyc), 32'(NPIX - 1));
    chk("auto_fill_busy_after", 32'(fill_busy), 32'd0);

    // Hand-derived vector table.
    idle_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    chk("tbl_reset_fb_we", 32'(fb_we), 32'd0);
    chk("tbl_reset_fb_addr", 32'(fb_addr), 32'd0);
    chk("tbl_reset_fill_done", 32'(fill_done), 32'd0);
    chk("tbl_busy_after_reset", 32'(fill_busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pix_we = tv[i].pw; pix_x = tv[i].px; pix_y = tv[i].py; pix_data = tv[i].pd;
      host_valid = tv[i].hv; host_addr = tv[i].ha; host_data = tv[i].hd;
      fill_start = tv[i].fs; fill_color = tv[i].fc;
      #3;
      chk($sformatf("tbl%0d_host_ready", i), 32'(host_ready), 32'(tv[i].e_rdy));
      @(posedge clk);
      #4;
      chk($sformatf("tbl%0d_fb_we", i), 32'(fb_we), 32'(tv[i].e_we));
      if (tv[i].e_we) begin
        chk($sformatf("tbl%0d_fb_addr", i), 32'(fb_addr), 32'(tv[i].e_addr));
        chk($sformatf("tbl%0d_fb_wdata", i), 32'(fb_wdata), 32'(tv[i].e_data));
      end
      chk($sformatf("tbl%0d_fill_done", i), 32'(fill_done), 32'd0);
    end
    idle_inputs();
    @(posedge clk);
    #1;

    // Restart at fill address 5000 with colour 0: one fill_done for the whole run.
    m_known = 0;
    model_reset();
    for (int i = 0; i < 6000 && !(m_act && m_ptr == 5000); i++) cyc();
    if (!(m_act && m_ptr == 5000)) timeout("reach_5000");
    fill_start = 1; fill_color = 18'h0;
    cyc();
    fill_start = 0;
    for (int i = 0; i < NPIX + 10 && m_act; i++) cyc();
    if (m_act) timeout("restart_fill");
    repeat (3) cyc();
    chk("restart_done_count", 32'(obs_done), 32'd1);

    // Randomized traffic.
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      pix_we     = ($urandom_range(0, 2) == 0);
      pix_x      = 8'($urandom_range(0, 255));
      pix_y      = 8'($urandom_range(0, 200));
      pix_data   = 18'($urandom);
      host_valid = ($urandom_range(0, 1) == 1);
      host_addr  = ($urandom_range(0, 7) == 0) ? 16'd38400 : 16'($urandom_range(0, 40000));
      host_data  = 18'($urandom);
      fill_start = ($urandom_range(0, 499) == 0);
      fill_color = 18'($urandom);
      cyc();
    end
    idle_inputs();
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
